// File: rtl/svnet_fifo_arbiter_if.sv
// Connects the burst arbiter to its upstream sources and to the write side of the shared downstream FIFO.
// The master modport is the arbiter's view. The slave modport is the environment's view.
interface svnet_fifo_arbiter_if #(
    parameter int WIDTH     = 1,
    parameter int PORTS     = 2,
    parameter int OUT_DEPTH = 1
);
    localparam int FSW = $clog2(OUT_DEPTH) + 1;

    logic [PORTS-1:0]       in_valid;
    logic [PORTS*WIDTH-1:0] in_data;
    logic [PORTS-1:0]       in_read;
    logic [FSW-1:0]         out_free_space;
    logic                   out_write;
    logic [WIDTH-1:0]       out_write_data;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_free_space,
        output in_read,
        output out_write,
        output out_write_data
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_free_space,
        input  in_read,
        input  out_write,
        input  out_write_data
    );
endinterface

// File: rtl/svnet_fifo_arbiter.sv
// Round-robin burst scheduler. It grants one upstream source at a time and moves up to BURST
// words per tenure into a shared downstream FIFO, gated by the FIFO's free space.
module svnet_fifo_arbiter #(
    parameter int WIDTH     = 1,
    parameter int PORTS     = 2,
    parameter int BURST     = 1,
    parameter int OUT_DEPTH = 1,
    localparam int OW       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svnet_fifo_arbiter_if.master bus,
    output logic                 busy,
    output logic [OW-1:0]        owner
);
    localparam int CW  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int FSW = $clog2(OUT_DEPTH) + 1;

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_BUSY  = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    logic [0:0]       state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             found_s;
    logic [OW-1:0]    pick_s;
    logic             own_valid_s;
    logic             xfer_s;
    logic [FSW-1:0]   free_s;
    logic [PORTS-1:0] in_read_s;
    logic [WIDTH-1:0] word_s [PORTS];

    // Adds an offset to a port index, wrapping modulo PORTS. The offset is at most PORTS-1.
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= PORTS) begin
            sum = sum - PORTS;
        end else begin
            sum = sum;
        end
        return sum[OW-1:0];
    endfunction

    assign free_s      = bus.out_free_space;
    assign own_valid_s = bus.in_valid[owner_q];
    assign xfer_s      = (state_q == ST_BUSY) && own_valid_s && (free_s != '0);

    // Split the packed source bus into per-port words.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            word_s[p] = bus.in_data[p*WIDTH +: WIDTH];
        end
    end

    // Round-robin search from ptr. Scanning from the far end lets the nearest valid source win.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            found_s = found_s | bus.in_valid[wrap_add(ptr_q, k)];
            pick_s  = bus.in_valid[wrap_add(ptr_q, k)] ? wrap_add(ptr_q, k) : pick_s;
        end
    end

    // Tenure control: grant in IDLE, count words and release in BUSY.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_BUSY;
                    owner_d = pick_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A source that runs dry gives up the port at once, even mid-burst.
                if (!own_valid_s || (xfer_s && (cnt_q == CNT_LAST))) begin
                    state_d = ST_IDLE;
                    ptr_d   = wrap_add(owner_q, 1);
                    cnt_d   = '0;
                end else if (xfer_s) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pop strobe goes only to the owner, and only while a word actually moves.
    always_comb begin
        in_read_s = '0;
        for (int p = 0; p < PORTS; p++) begin
            in_read_s[p] = xfer_s && (owner_q == OW'(p));
        end
    end

    assign bus.in_read        = in_read_s;
    assign bus.out_write      = xfer_s;
    assign bus.out_write_data = word_s[owner_q];
    assign busy               = (state_q == ST_BUSY);
    assign owner              = owner_q;

    // State registers. An asynchronous reset aborts any tenure in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    svnet_fifo_arbiter_chk #(
        .PORTS (PORTS),
        .FSW   (FSW)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (bus.in_valid),
        .in_read        (in_read_s),
        .out_free_space (free_s),
        .out_write      (xfer_s)
    );
endmodule

// Handshake invariants of the arbiter.
module svnet_fifo_arbiter_chk #(
    parameter int PORTS = 2,
    parameter int FSW   = 1
) (
    input logic             clk,
    input logic             rst_n,
    input logic [PORTS-1:0] in_valid,
    input logic [PORTS-1:0] in_read,
    input logic [FSW-1:0]   out_free_space,
    input logic             out_write
);
    a_write_needs_space: assert property (@(posedge clk) disable iff (!rst_n)
        out_write |-> (out_free_space != '0));
    a_read_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        ((in_read & ~in_valid) == '0));
    a_read_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_read));
    a_write_matches_read: assert property (@(posedge clk) disable iff (!rst_n)
        (out_write == (|in_read)));
endmodule

// File: tb/tb_svnet_fifo_arbiter.sv
// Directed vector bench for svnet_fifo_arbiter: a 4-port/burst-4 instance and a 3-port/burst-1 instance.
module tb_svnet_fifo_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    svnet_fifo_arbiter_if #(.WIDTH(8), .PORTS(4), .OUT_DEPTH(8)) a_if ();
    svnet_fifo_arbiter_if #(.WIDTH(8), .PORTS(3), .OUT_DEPTH(4)) b_if ();

    logic       a_busy;
    logic [1:0] a_owner;
    logic       b_busy;
    logic [1:0] b_owner;

    svnet_fifo_arbiter #(.WIDTH(8), .PORTS(4), .BURST(4), .OUT_DEPTH(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if),
        .busy  (a_busy),
        .owner (a_owner)
    );

    svnet_fifo_arbiter #(.WIDTH(8), .PORTS(3), .BURST(1), .OUT_DEPTH(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if),
        .busy  (b_busy),
        .owner (b_owner)
    );

    // One cycle: source inputs plus expected outputs (busy/owner show the state in that cycle).
    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] fs;
        logic       busy;
        logic [1:0] owner;
        logic       wr;
        logic [3:0] rd;
        logic [7:0] data;
    } vec_t;

    vec_t va [49];
    vec_t vb [13];

    // Source models: word = {port, sequence number}; the sequence advances when the port is popped.
    logic [5:0] a_seq [4];
    logic [3:0] a_rd;
    logic [5:0] b_seq [3];
    logic [2:0] b_rd;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] fs, input logic b,
                                input logic [1:0] o, input logic w, input logic [3:0] r,
                                input logic [7:0] d);
        vec_t t;
        t.valid = v; t.fs = fs; t.busy = b; t.owner = o; t.wr = w; t.rd = r; t.data = d;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_a(input logic [3:0] v, input logic [3:0] fs);
        for (int p = 0; p < 4; p++) begin
            if (a_rd[p]) a_seq[p] = a_seq[p] + 6'd1;
            a_if.in_data[p*8 +: 8] = {2'(p), a_seq[p]};
        end
        a_rd = 4'b0000;
        a_if.in_valid       = v;
        a_if.out_free_space = fs;
    endtask

    task automatic drive_b(input logic [2:0] v, input logic [2:0] fs);
        for (int p = 0; p < 3; p++) begin
            if (b_rd[p]) b_seq[p] = b_seq[p] + 6'd1;
            b_if.in_data[p*8 +: 8] = {2'(p), b_seq[p]};
        end
        b_rd = 3'b000;
        b_if.in_valid       = v;
        b_if.out_free_space = fs;
    endtask

    task automatic step_a(input int idx, input vec_t t);
        @(negedge clk);
        drive_a(t.valid, t.fs);
        #1;
        chk("a_busy",  idx, 32'(a_busy),              32'(t.busy));
        chk("a_owner", idx, 32'(a_owner),             32'(t.owner));
        chk("a_write", idx, 32'(a_if.out_write),      32'(t.wr));
        chk("a_read",  idx, 32'(a_if.in_read),        32'(t.rd));
        chk("a_data",  idx, 32'(a_if.out_write_data), 32'(t.data));
        a_rd = a_if.in_read;
    endtask

    task automatic step_b(input int idx, input vec_t t);
        @(negedge clk);
        drive_b(t.valid[2:0], t.fs[2:0]);
        #1;
        chk("b_busy",  idx, 32'(b_busy),              32'(t.busy));
        chk("b_owner", idx, 32'(b_owner),             32'(t.owner));
        chk("b_write", idx, 32'(b_if.out_write),      32'(t.wr));
        chk("b_read",  idx, 32'(b_if.in_read),        32'(t.rd[2:0]));
        chk("b_data",  idx, 32'(b_if.out_write_data), 32'(t.data));
        b_rd = b_if.in_read;
    endtask

    initial begin
        // Source 2 alone, 10 words: bursts of 4,4,2 separated by one idle cycle
        va[0]  = mk(4'b0100, 4'd8, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        va[1]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h80);
        va[2]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h81);
        va[3]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h82);
        va[4]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h83);
        va[5]  = mk(4'b0100, 4'd8, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h84);
        va[6]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h84);
        va[7]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h85);
        va[8]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h86);
        va[9]  = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h87);
        va[10] = mk(4'b0100, 4'd8, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h88);
        va[11] = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h88);
        va[12] = mk(4'b0100, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h89);
        va[13] = mk(4'b0000, 4'd8, 1'b1, 2'd2, 1'b0, 4'b0000, 8'h8A);
        va[14] = mk(4'b0000, 4'd8, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h8A);
        // All sources valid: round robin starting at ptr=3
        va[15] = mk(4'b1111, 4'd8, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h8A);
        va[16] = mk(4'b1111, 4'd8, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hC0);
        va[17] = mk(4'b1111, 4'd8, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hC1);
        va[18] = mk(4'b1111, 4'd8, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hC2);
        va[19] = mk(4'b1111, 4'd8, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hC3);
        va[20] = mk(4'b1111, 4'd8, 1'b0, 2'd3, 1'b0, 4'b0000, 8'hC4);
        va[21] = mk(4'b1111, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h00);
        va[22] = mk(4'b1111, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h01);
        va[23] = mk(4'b1111, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h02);
        va[24] = mk(4'b1111, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h03);
        va[25] = mk(4'b1111, 4'd8, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h04);
        va[26] = mk(4'b1111, 4'd8, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h40);
        va[27] = mk(4'b1111, 4'd8, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h41);
        // Downstream full for 5 cycles mid-burst, then one free slot
        va[28] = mk(4'b1111, 4'd0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h42);
        va[29] = mk(4'b1111, 4'd0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h42);
        va[30] = mk(4'b1111, 4'd0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h42);
        va[31] = mk(4'b1111, 4'd0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h42);
        va[32] = mk(4'b1111, 4'd0, 1'b1, 2'd1, 1'b0, 4'b0000, 8'h42);
        va[33] = mk(4'b1111, 4'd1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h42);
        va[34] = mk(4'b1111, 4'd8, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h43);
        va[35] = mk(4'b1111, 4'd8, 1'b0, 2'd1, 1'b0, 4'b0000, 8'h44);
        // Source 2 runs dry after 3 words: same-cycle release, then source 3
        va[36] = mk(4'b1111, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h8A);
        va[37] = mk(4'b1111, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h8B);
        va[38] = mk(4'b1111, 4'd8, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h8C);
        va[39] = mk(4'b1011, 4'd8, 1'b1, 2'd2, 1'b0, 4'b0000, 8'h8D);
        va[40] = mk(4'b1011, 4'd8, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h8D);
        va[41] = mk(4'b1011, 4'd8, 1'b1, 2'd3, 1'b1, 4'b1000, 8'hC4);
        va[42] = mk(4'b0000, 4'd8, 1'b1, 2'd3, 1'b0, 4'b0000, 8'hC5);
        va[43] = mk(4'b0000, 4'd8, 1'b0, 2'd3, 1'b0, 4'b0000, 8'hC5);
        // Move ptr to 1, then leave source 1 mid-burst for the reset sequence
        va[44] = mk(4'b0001, 4'd8, 1'b0, 2'd3, 1'b0, 4'b0000, 8'hC5);
        va[45] = mk(4'b0001, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h04);
        va[46] = mk(4'b0000, 4'd8, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h05);
        va[47] = mk(4'b0010, 4'd8, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h05);
        va[48] = mk(4'b0010, 4'd8, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h44);

        // 3 ports, BURST=1: pointer wraps 2 -> 0, BUSY/IDLE alternate
        vb[0]  = mk(4'b0100, 4'd4, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
        vb[1]  = mk(4'b0100, 4'd4, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h80);
        vb[2]  = mk(4'b0101, 4'd4, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h81);
        vb[3]  = mk(4'b0101, 4'd1, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h00);
        vb[4]  = mk(4'b0101, 4'd4, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h01);
        vb[5]  = mk(4'b0101, 4'd4, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h81);
        vb[6]  = mk(4'b0111, 4'd4, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h82);
        vb[7]  = mk(4'b0111, 4'd4, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h01);
        vb[8]  = mk(4'b0111, 4'd4, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h02);
        vb[9]  = mk(4'b0111, 4'd1, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h40);
        vb[10] = mk(4'b0111, 4'd4, 1'b0, 2'd1, 1'b0, 4'b0000, 8'h41);
        vb[11] = mk(4'b0111, 4'd4, 1'b1, 2'd2, 1'b1, 4'b0100, 8'h82);
        vb[12] = mk(4'b0000, 4'd4, 1'b0, 2'd2, 1'b0, 4'b0000, 8'h83);

        for (int p = 0; p < 4; p++) a_seq[p] = 6'd0;
        for (int p = 0; p < 3; p++) b_seq[p] = 6'd0;
        a_rd  = 4'b0000;
        b_rd  = 3'b000;
        rst_n = 1'b0;

        // Reset state with all sources requesting
        drive_a(4'b1111, 4'd8);
        drive_b(3'b111, 3'd4);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_busy",  0, 32'(a_busy),              32'd0);
        chk("rst_a_owner", 0, 32'(a_owner),             32'd0);
        chk("rst_a_write", 0, 32'(a_if.out_write),      32'd0);
        chk("rst_a_read",  0, 32'(a_if.in_read),        32'd0);
        chk("rst_a_data",  0, 32'(a_if.out_write_data), 32'h00);
        chk("rst_b_busy",  0, 32'(b_busy),              32'd0);
        chk("rst_b_read",  0, 32'(b_if.in_read),        32'd0);
        chk("rst_b_write", 0, 32'(b_if.out_write),      32'd0);
        a_if.in_valid = 4'b0000;
        b_if.in_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 49; i++) step_a(i, va[i]);

        // Reset asserted while source 1 is mid-burst: outputs drop at once, nothing popped
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  0, 32'(a_busy),              32'd0);
        chk("mid_rst_owner", 0, 32'(a_owner),             32'd0);
        chk("mid_rst_write", 0, 32'(a_if.out_write),      32'd0);
        chk("mid_rst_read",  0, 32'(a_if.in_read),        32'd0);
        chk("mid_rst_data",  0, 32'(a_if.out_write_data), 32'h05);
        a_rd = a_if.in_read;
        a_if.in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        // Sources 0 and 1 both valid: grant must come from ptr=0
        step_a(100, mk(4'b0011, 4'd8, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h05));
        step_a(101, mk(4'b0011, 4'd8, 1'b1, 2'd0, 1'b1, 4'b0001, 8'h05));
        step_a(102, mk(4'b0000, 4'd8, 1'b1, 2'd0, 1'b0, 4'b0000, 8'h06));

        for (int i = 0; i < 13; i++) step_b(i, vb[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/svnet_fifo_arbiter.md
# svnet_fifo_arbiter

Round-robin burst scheduler that shares the write port of one downstream SVNet FIFO (register or RAM FIFO) between PORTS upstream sources. Each source exposes "data available" plus a pop strobe (typically a FIFO's used_space != 0 and read). The block owns one source at a time and moves up to BURST words per tenure into the downstream FIFO, gated by the downstream free_space. It sits between parallel layer-output FIFOs and a shared memory/output FIFO.

## Interface
- WIDTH, 1, data word width
- PORTS, 2, number of upstream sources (>= 2)
- BURST, 1, max words transferred per tenure (>= 1)
- OUT_DEPTH, 1, depth of downstream FIFO (sizes out_free_space)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  PORTS  bit i: source i has a word available
- in_data  input  PORTS*WIDTH  source i word at bits [i*WIDTH +: WIDTH]
- in_read  output  PORTS  bit i: pop source i this cycle
- out_free_space  input  $clog2(OUT_DEPTH)+1  downstream free_space
- out_write  output  1  write downstream this cycle
- out_write_data  output  WIDTH  word written downstream
- busy  output  1  a source currently owns the port
- owner  output  $clog2(PORTS) (min 1)  index of owning source

## Operation
- State: state {IDLE, BUSY}, owner, ptr (round-robin start), cnt (0..BURST-1).
- IDLE: search i = ptr, ptr+1, ... wrapping mod PORTS, first i with in_valid[i]. If found: next owner = i, cnt = 0, state = BUSY. No transfer in IDLE. None found: stay IDLE.
- BUSY: xfer = in_valid[owner] && (out_free_space != 0). Combinationally: out_write = xfer, in_read = xfer one-hot at owner, out_write_data = in_data[owner]. On xfer cnt += 1.
- Release (BUSY -> IDLE, ptr = owner+1 wrapping PORTS-1 -> 0): (xfer && cnt == BURST-1) or !in_valid[owner]. Release on !in_valid takes effect the same cycle (no transfer that cycle).
- Downstream full (out_free_space == 0) with in_valid[owner]: hold owner, cnt unchanged, no release; no timeout.
- out_write_data always equals in_data[owner] (also in IDLE); consumers qualify with out_write.
- busy = (state == BUSY). in_read bits other than owner always 0; in_read all 0 in IDLE.
- Assertions: out_write |-> out_free_space != 0; in_read[i] |-> in_valid[i]; $onehot0(in_read); out_write == |in_read.

## Timing
- Reset (async assert, sync release): state IDLE, owner 0, ptr 0, cnt 0; busy 0, out_write 0, in_read 0, out_write_data = in_data[0]. Reset mid-burst aborts tenure; no word popped without a matching write.
- Arbitration latency: in_valid[i] rising at cycle N with port idle -> busy, owner = i at N+1, first out_write at N+1 (if free space).
- Streaming: BURST words on consecutive cycles when source valid and space available, then one IDLE bubble. Sustained throughput BURST/(BURST+1) per cycle.
- Combinational paths: in_valid, in_data, out_free_space -> out_write, in_read, out_write_data. No path from inputs to busy/owner.
- BURST == 1: each tenure is exactly one transfer, alternating BUSY/IDLE.
- Fairness: a continuously valid source waits at most (PORTS-1)*(BURST+1) cycles plus downstream stalls.

## Test plan
- Single source: PORTS=4, BURST=4, only in_valid[2] high, 10 words, ample space -> writes words in order; bursts of 4,4,2 with one-cycle gaps; owner=2 throughout busy cycles.
- Round-robin: all 4 valid forever, BURST=2 -> owner sequence 0,1,2,3,0..., each tenure exactly 2 writes, 1 bubble between.
- Backpressure: owner 1, out_free_space=0 for 5 cycles mid-burst -> out_write=0, in_read=0, owner held; resumes with remaining burst count, no words lost/duplicated.
- Early release: BURST=8, source 0 drops in_valid after 3 words -> 3 writes, IDLE next cycle, ptr=1; source 1 (valid) owns on following cycle.
- Wrap/pointer: PORTS=3, only source 2 then source 0 valid -> after owner 2 release, ptr=0, source 0 selected next.
- Reset mid-burst: assert rst_n low during BUSY -> busy=0, out_write=0, in_read=0 immediately; after release, first grant from ptr=0.
